cpu_ctrl: RTL
=============

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: imem_addr  out  8  fetch address (PC).
REQ-004 SHALL have port: imem_rd  out  1  fetch request.
REQ-005 SHALL have port: imem_data  in  8  instruction word, valid when imem_ack=1.
REQ-006 SHALL have port: imem_ack  in  1  fetch completion.
REQ-007 SHALL have ports: rf_ra  out  2 and rf_rb  out  2  register-file read selects feeding ALU a/b.
REQ-008 SHALL have ports: rf_we  out  1 and rf_wa  out  2  register-file write enable and address; write data is the ALU result.
REQ-009 SHALL have port: alu_op  out  3  ALU operation select, same encoding as the CPU ALU.
REQ-010 SHALL have port: alu_zero  in  1  ALU zero flag.
REQ-011 SHALL have ports: flag_z  out  1 (registered zero flag), halted  out  1, fault  out  1.

Function
REQ-012 SHALL decode the instruction as op=[7:5], rd=[4:3], rs=[1:0], target=[4:0].
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 SLT: rd <= ALU(rd, rs).
- 110 BZ: PC <= {3'b000,target} if flag_z=1, else PC+1.
- 111 HALT.
REQ-013 SHALL implement FSM states FETCH, DECODE, EXEC, WB, HALT.
REQ-014 FETCH SHALL:
- hold imem_rd=1 and imem_addr=PC until imem_ack=1;
- latch imem_data into IR on the ack cycle;
- go to DECODE on the next cycle.
REQ-015 DECODE SHALL last 1 cycle:
- op 111 -> HALT;
- op 110 -> EXEC with no ALU activity;
- otherwise -> EXEC.
REQ-016 EXEC SHALL last 1 cycle:
- ALU ops: drive alu_op=op, rf_ra=rd, rf_rb=rs, then -> WB.
- BZ: update PC per REQ-012, then -> FETCH.
REQ-017 WB SHALL last 1 cycle:
- hold alu_op/rf_ra/rf_rb from EXEC;
- rf_we=1, rf_wa=rd;
- flag_z <= alu_zero; PC <= PC+1;
- -> FETCH.
REQ-018 rf_we SHALL be 1 only in WB, and no register write SHALL occur for BZ or HALT.
REQ-019 alu_op SHALL be 3'b000 and rf_ra/rf_rb SHALL be 0 outside EXEC/WB.
REQ-020 ALU instruction latency SHALL be 4 cycles with ack on the first FETCH cycle, plus 1 cycle per extra wait cycle; BZ latency SHALL be 3 cycles.
REQ-021 PC SHALL be 8-bit unsigned and wrap from 255 to 0.
REQ-022 flag_z SHALL change only in WB, so BZ tests the most recent ALU result.
REQ-023 HALT SHALL be absorbing until rst: halted=1, imem_rd=0, rf_we=0.
REQ-024 imem_ack outside FETCH SHALL be ignored.
REQ-025 imem_data SHALL be sampled only on an ack cycle in FETCH.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set:
- state=FETCH, PC=0, IR=0;
- flag_z=0, halted=0, fault=0;
- rf_we=0, alu_op=0.
REQ-027 rst SHALL override every state, including mid-FETCH wait, WB and HALT.
REQ-028 On the first cycle after a mid-operation reset, no write SHALL occur and no pending fetch SHALL be honoured.
REQ-029 imem_rd SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 The macro CPU_CTRL_FETCH_TIMEOUT_EN SHALL control the fetch timeout.
- Defined: a 4-bit counter counts FETCH wait cycles without ack. It clears on entry to FETCH. When it reaches 15 without ack, the next cycle enters HALT with fault=1 and halted=1. An ack on the 15th wait cycle is accepted normally.
- Undefined: FETCH waits indefinitely; fault is constant 0; no counter logic.

Verification
REQ-031 ADD: imem_data=8'b000_01_0_10 acked immediately.
- rf_we=1, rf_wa=1, rf_ra=1, rf_rb=2, alu_op=000 exactly 3 cycles after the ack cycle (WB cycle);
- next fetch at imem_addr=1.
REQ-032 SUB with alu_zero=1 in WB, then BZ 8'b110_10100 -> flag_z=1, next imem_addr=20. Same BZ with flag_z=0 -> next imem_addr = BZ address+1.
REQ-033 ack delayed 5 cycles -> imem_rd stays 1 and imem_addr stable for 6 cycles; IR takes the data present on the ack cycle only.
REQ-034 PC=255 executing OR -> next imem_addr=0. HALT 8'hE0 -> halted=1 and imem_rd=0 permanently until rst.
REQ-035 rst asserted during WB -> no rf_we in the following cycle; imem_addr=0, flag_z=0, state FETCH.
REQ-036 With CPU_CTRL_FETCH_TIMEOUT_EN defined and no ack -> fault=1 and halted=1 after the 15-cycle timeout. Ack on wait cycle 15 -> normal decode, fault=0.

Source files
------------

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit for a small 8-bit accumulator-style CPU.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> WB. The unit
// drives the instruction fetch port, the register-file read/write selects and
// the ALU operation. It also keeps the program counter, the instruction
// register and a registered zero flag.
//
// Instruction word: op=[7:5], rd=[4:3], rs=[1:0], branch target=[4:0]
//   000 ADD  001 SUB  010 AND  011 OR  100 NOT  101 SLT : rd <= ALU(rd, rs)
//   110 BZ   : pc <= target if flag_z else pc+1
//   111 HALT
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_addr/imem_rd         fetch address (pc) and fetch request
//   imem_data/imem_ack        instruction word and fetch completion
//   rf_ra/rf_rb               register-file read selects (ALU a/b)
//   rf_we/rf_wa               register-file write enable/address (data = ALU result)
//   alu_op/alu_zero           ALU operation select and ALU zero flag
//   flag_z/halted/fault       registered zero flag, halt and fetch-timeout status
//
// Build option: CPU_CTRL_FETCH_TIMEOUT_EN adds a fetch timeout. If no ack
// arrives within the first fetch cycle plus 15 wait cycles, the unit halts
// with fault=1. Without the macro, fetch waits forever and fault is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | imem_rd=1 at pc; latch imem_data into ir on ack
// DECODE | one cycle; HALT opcode goes to HALT, everything else to EXEC
// EXEC   | ALU op: drive alu_op/rf_ra/rf_rb; BZ: resolve pc
// WB     | write rd, capture alu_zero into flag_z, pc+1
// HALT   | absorbing until rst; no fetch, no writes

module cpu_ctrl (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  output logic       imem_rd,
  input  logic [7:0] imem_data,
  input  logic       imem_ack,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic [2:0] alu_op,
  input  logic       alu_zero,
  output logic       flag_z,
  output logic       halted,
  output logic       fault
);

  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic [7:0] ir, ir_nxt;
  logic       flag_z_nxt;

  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [4:0] target;
  logic       is_alu;

  assign op     = ir[7:5];
  assign rd     = ir[4:3];
  assign rs     = ir[1:0];
  assign target = ir[4:0];
  assign is_alu = (op != OP_BZ) && (op != OP_HALT);

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
  // Down-counter of remaining wait cycles; reloaded on every entry to FETCH.
  // Terminal count 0 means 15 wait cycles have already passed without ack, so
  // an ack in this cycle is still accepted and only a miss times out.
  localparam logic [3:0] FETCH_WAIT_MAX = 4'd15;
  logic [3:0] fetch_timer, fetch_timer_nxt;
  logic       fault_q, fault_nxt;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    flag_z_nxt = flag_z;
    imem_rd    = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = 2'd0;
    rf_ra      = 2'd0;
    rf_rb      = 2'd0;
    alu_op     = 3'd0;
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
    fetch_timer_nxt = fetch_timer;
    fault_nxt       = fault_q;
`endif

    case (state)
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_data;
          state_nxt = S_DECODE;
        end
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
        else if (fetch_timer == 4'd0) begin
          state_nxt = S_HALT;
          fault_nxt = 1'b1;
        end else begin
          fetch_timer_nxt = fetch_timer - 4'd1;
        end
`endif
      end

      S_DECODE: begin
        state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        if (is_alu) begin
          alu_op    = op;
          rf_ra     = rd;
          rf_rb     = rs;
          state_nxt = S_WB;
        end else begin
          // Only BZ reaches EXEC without an ALU op; HALT leaves from DECODE.
          pc_nxt    = flag_z ? {3'b000, target} : pc + 8'd1;
          state_nxt = S_FETCH;
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
          fetch_timer_nxt = FETCH_WAIT_MAX;
`endif
        end
      end

      S_WB: begin
        // ALU selects are held so the result stays valid for the write.
        alu_op     = op;
        rf_ra      = rd;
        rf_rb      = rs;
        rf_we      = 1'b1;
        rf_wa      = rd;
        flag_z_nxt = alu_zero;
        pc_nxt     = pc + 8'd1;
        state_nxt  = S_FETCH;
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
        fetch_timer_nxt = FETCH_WAIT_MAX;
`endif
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= 8'd0;
      ir     <= 8'd0;
      flag_z <= 1'b0;
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
      fetch_timer <= FETCH_WAIT_MAX;
      fault_q     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      flag_z <= flag_z_nxt;
`ifdef CPU_CTRL_FETCH_TIMEOUT_EN
      fetch_timer <= fetch_timer_nxt;
      fault_q     <= fault_nxt;
`endif
    end
  end

endmodule
